pixel_frame_sequencer: RTL and testbench
========================================

PIXEL_FRAME_SEQUENCER -- requirements
Module: pixel_frame_sequencer

Interface
REQ-001 Parameter WIDTH, default 2, pixel columns.
REQ-002 Parameter HEIGHT, default 2, pixel rows.
REQ-003 Parameter OUTPUT_BUS_PIXEL_WIDTH, default 2, pixels per readout word; WIDTH*HEIGHT SHALL be a multiple of it (elaboration error otherwise).
REQ-004 Parameter BIT_DEPTH, default 8, ADC code width.
REQ-005 Parameter ERASE_CYCLES, default 5, ERASE phase length (>=1).
REQ-006 Ports: SYSTEM_CLK, in, 1, sole clock, all logic rising-edge.
REQ-007 SYSTEM_RESET, in, 1, asynchronous, active-low reset.
REQ-008 START, in, 1, request one frame; sampled in IDLE only.
REQ-009 CONTINUOUS, in, 1, 1 = restart the next frame automatically; sampled at DONE.
REQ-010 ABORT, in, 1, terminate the current frame.
REQ-011 EXPOSURE_CYCLES, in, 16, exposure length; latched on IDLE->ERASE.
REQ-012 Outputs, each 1 bit: POWER_ENABLE, WRITE_ENABLE, COUNTER_RESET, COUNTER_CLOCK, RESET, ERASE, EXPOSE, READ_RESET, READ_CLK_IN (pixel array controls).
REQ-013 RAMP_CODE, out, BIT_DEPTH, digital ramp value during CONVERT.
REQ-014 BUSY, out, 1, high in every state except IDLE.
REQ-015 FRAME_DONE, out, 1, one-cycle pulse per completed frame.
REQ-016 FRAME_COUNT, out, 16, count of completed frames.

Function
REQ-017 States: IDLE, ERASE, EXPOSE, CONVERT, READ, DONE; all outputs SHALL be registered.
REQ-018 IDLE: all controls low; START=1 -> ERASE next cycle.
REQ-019 ERASE: RESET=1 and ERASE=1 for exactly ERASE_CYCLES cycles, then -> EXPOSE.
REQ-020 EXPOSE: EXPOSE=1 for max(latched EXPOSURE_CYCLES, 1) cycles, then -> CONVERT.
REQ-021 CONVERT: POWER_ENABLE=1 and WRITE_ENABLE=1 throughout; COUNTER_RESET=1 on the first cycle only; then 2^BIT_DEPTH cycles with RAMP_CODE stepping 0..2^BIT_DEPTH-1, one per cycle, and COUNTER_CLOCK high on each of these cycles (low on the reset cycle); then -> READ.
REQ-022 RAMP_CODE SHALL hold 0 outside CONVERT; the ramp counter SHALL NOT wrap to 0 inside CONVERT.
REQ-023 READ: READ_RESET=1 for one cycle; then NUM_WORDS = WIDTH*HEIGHT/OUTPUT_BUS_PIXEL_WIDTH periods of READ_CLK_IN, each one cycle high followed by one cycle low; then -> DONE.
REQ-024 DONE (one cycle): FRAME_DONE=1; FRAME_COUNT increments modulo 2^16; CONTINUOUS=1 -> ERASE, relatching EXPOSURE_CYCLES; otherwise -> IDLE.
REQ-025 ABORT=1 in any non-IDLE state -> IDLE next cycle; all controls low; no FRAME_DONE; FRAME_COUNT unchanged.
REQ-026 ABORT takes priority over START and over every phase transition on the same cycle; ABORT in IDLE SHALL have no effect.
REQ-027 START outside IDLE SHALL be ignored, not queued.
REQ-028 EXPOSURE_CYCLES changes after latching SHALL NOT affect the current frame.

Reset
REQ-029 On SYSTEM_RESET low: state IDLE; all 1-bit outputs 0; RAMP_CODE 0; FRAME_COUNT 0; latched exposure 0.
REQ-030 Reset asserted mid-frame SHALL take effect immediately, without waiting for a clock edge; after release the block SHALL wait in IDLE for START.

Structure
REQ-031 Package pixel_pkg SHALL hold the state enum, the NUM_WORDS function and the default ERASE_CYCLES constant.
REQ-032 Sub-module pixel_phase_counter (loadable down-counter, load/enable/zero flag, parametrised width) SHALL time the ERASE, EXPOSE and READ phases.
REQ-033 The pixel_frame_sequencer ports SHALL use the same names as the pixel array's control inputs, so the array connects one-to-one.

Verification
REQ-034 Defaults: START pulse, EXPOSURE_CYCLES=10 -> ERASE 5 cycles, EXPOSE 10, CONVERT 257, READ 1+4 cycles, FRAME_DONE once, FRAME_COUNT=1, BUSY low afterwards.
REQ-035 EXPOSURE_CYCLES=0 -> EXPOSE high exactly 1 cycle.
REQ-036 CONTINUOUS=1 for 3 frames, EXPOSURE_CYCLES changed mid-frame -> frames back-to-back (DONE->ERASE); the new value is used only from the next frame; FRAME_COUNT=3.
REQ-037 ABORT at CONVERT cycle 100 -> IDLE next cycle; RAMP_CODE=0; no FRAME_DONE; START accepted afterwards.
REQ-038 SYSTEM_RESET low during READ -> outputs cleared asynchronously, FRAME_COUNT=0; FRAME_COUNT preset to 0xFFFF -> wraps to 0 at DONE.
REQ-039 WIDTH=4, HEIGHT=4, OUTPUT_BUS_PIXEL_WIDTH=4, BIT_DEPTH=4 -> exactly 4 READ_CLK_IN pulses; RAMP_CODE runs 0..15.

Source files
------------

// File: rtl/pixel_pkg.sv
// Shared types and helpers for the pixel frame sequencer.
package pixel_pkg;

  localparam int unsigned ERASE_CYCLES_DEFAULT = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ERASE,
    ST_EXPOSE,
    ST_CONVERT,
    ST_READ,
    ST_DONE
  } state_e;

  // Registered 1-bit controls and status driven towards the pixel array.
  typedef struct packed {
    logic busy;
    logic frame_done;
    logic power_enable;
    logic write_enable;
    logic counter_reset;
    logic counter_clock;
    logic reset;
    logic erase;
    logic expose;
    logic read_reset;
    logic read_clk_in;
  } ctrl_t;

  function automatic int unsigned num_words(input int unsigned width,
                                            input int unsigned height,
                                            input int unsigned bus_pixels);
    return (width * height) / bus_pixels;
  endfunction

endpackage

// File: rtl/pixel_phase_counter.sv
// Loadable down-counter with a registered zero flag; times the fixed-length frame phases.
module pixel_phase_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] count_q, count_d;
  logic         zero_q;

  // Load wins over counting; the count parks at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
      zero_q  <= 1'b1;
    end else begin
      count_q <= count_d;
      zero_q  <= (count_d == '0);
    end
  end

  assign zero_o = zero_q;

endmodule

// File: rtl/pixel_frame_sequencer.sv
// Pixel array frame sequencer: erase, expose, ramp conversion and word readout, one frame at a time.
module pixel_frame_sequencer
  import pixel_pkg::*;
#(
  parameter int unsigned WIDTH                  = 2,
  parameter int unsigned HEIGHT                 = 2,
  parameter int unsigned OUTPUT_BUS_PIXEL_WIDTH = 2,
  parameter int unsigned BIT_DEPTH              = 8,
  parameter int unsigned ERASE_CYCLES           = ERASE_CYCLES_DEFAULT
) (
  input  logic                 SYSTEM_CLK,
  input  logic                 SYSTEM_RESET,
  input  logic                 START,
  input  logic                 CONTINUOUS,
  input  logic                 ABORT,
  input  logic [15:0]          EXPOSURE_CYCLES,
  output logic                 POWER_ENABLE,
  output logic                 WRITE_ENABLE,
  output logic                 COUNTER_RESET,
  output logic                 COUNTER_CLOCK,
  output logic                 RESET,
  output logic                 ERASE,
  output logic                 EXPOSE,
  output logic                 READ_RESET,
  output logic                 READ_CLK_IN,
  output logic [BIT_DEPTH-1:0] RAMP_CODE,
  output logic                 BUSY,
  output logic                 FRAME_DONE,
  output logic [15:0]          FRAME_COUNT
);

  localparam int unsigned NUM_WORDS = num_words(WIDTH, HEIGHT, OUTPUT_BUS_PIXEL_WIDTH);
  localparam int unsigned READ_LOAD = 2 * NUM_WORDS;
  localparam int unsigned ERASE_W   = (ERASE_CYCLES > 1) ? $clog2(ERASE_CYCLES) : 1;
  localparam int unsigned READ_W    = $clog2(READ_LOAD + 1);
  localparam int unsigned BASE_W    = (ERASE_W > 16) ? ERASE_W : 16;
  localparam int unsigned CNT_W     = (READ_W > BASE_W) ? READ_W : BASE_W;

  localparam logic [CNT_W-1:0]     ERASE_LOAD = CNT_W'(ERASE_CYCLES - 1);
  localparam logic [CNT_W-1:0]     READ_VAL   = CNT_W'(READ_LOAD);
  localparam logic [BIT_DEPTH-1:0] RAMP_MAX   = '1;

  if ((WIDTH * HEIGHT) % OUTPUT_BUS_PIXEL_WIDTH != 0) begin : g_bus_check
    $error("pixel_frame_sequencer: WIDTH*HEIGHT must be a multiple of OUTPUT_BUS_PIXEL_WIDTH");
  end
  if (ERASE_CYCLES < 1) begin : g_erase_check
    $error("pixel_frame_sequencer: ERASE_CYCLES must be at least 1");
  end

  state_e               state_q, state_d;
  ctrl_t                ctrl_q, ctrl_d;
  logic [15:0]          exp_q, exp_d;
  logic [15:0]          frame_count_q, frame_count_d;
  logic [BIT_DEPTH-1:0] ramp_q, ramp_d;
  logic                 cnt_load;
  logic [CNT_W-1:0]     cnt_val;
  logic                 cnt_zero;

  pixel_phase_counter #(
    .W (CNT_W)
  ) u_phase_counter (
    .clk_i      (SYSTEM_CLK),
    .rst_n_i    (SYSTEM_RESET),
    .load_i     (cnt_load),
    .en_i       (1'b1),
    .load_val_i (cnt_val),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge SYSTEM_CLK or negedge SYSTEM_RESET) begin
    if (!SYSTEM_RESET) begin
      state_q       <= ST_IDLE;
      ctrl_q        <= '0;
      exp_q         <= '0;
      frame_count_q <= '0;
      ramp_q        <= '0;
    end else begin
      state_q       <= state_d;
      ctrl_q        <= ctrl_d;
      exp_q         <= exp_d;
      frame_count_q <= frame_count_d;
      ramp_q        <= ramp_d;
    end
  end

  // Next state, phase timer loads, and the outputs the next state will present.
  always_comb begin
    state_d       = state_q;
    exp_d         = exp_q;
    ramp_d        = '0;
    frame_count_d = frame_count_q;
    cnt_load      = 1'b0;
    cnt_val       = '0;
    ctrl_d        = '0;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d  = ST_ERASE;
          exp_d    = EXPOSURE_CYCLES;
          cnt_load = 1'b1;
          cnt_val  = ERASE_LOAD;
        end
      end
      ST_ERASE: begin
        if (cnt_zero) begin
          state_d  = ST_EXPOSE;
          cnt_load = 1'b1;
          cnt_val  = (exp_q == '0) ? '0 : CNT_W'(exp_q - 16'd1);
        end
      end
      ST_EXPOSE: begin
        if (cnt_zero) begin
          state_d = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        // The counter-clock bit doubles as "ramp running"; it is low on the reset cycle.
        if (ctrl_q.counter_clock) begin
          if (ramp_q == RAMP_MAX) begin
            state_d  = ST_READ;
            cnt_load = 1'b1;
            cnt_val  = READ_VAL;
          end else begin
            ramp_d = ramp_q + BIT_DEPTH'(1);
          end
        end
      end
      ST_READ: begin
        if (cnt_zero) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (CONTINUOUS) begin
          state_d  = ST_ERASE;
          exp_d    = EXPOSURE_CYCLES;
          cnt_load = 1'b1;
          cnt_val  = ERASE_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (ABORT && (state_q != ST_IDLE)) begin
      state_d  = ST_IDLE;
      exp_d    = exp_q;
      ramp_d   = '0;
      cnt_load = 1'b0;
    end

    if (state_d == ST_DONE) begin
      frame_count_d = frame_count_q + 16'd1;
    end

    ctrl_d.busy          = (state_d != ST_IDLE);
    ctrl_d.frame_done    = (state_d == ST_DONE);
    ctrl_d.reset         = (state_d == ST_ERASE);
    ctrl_d.erase         = (state_d == ST_ERASE);
    ctrl_d.expose        = (state_d == ST_EXPOSE);
    ctrl_d.power_enable  = (state_d == ST_CONVERT);
    ctrl_d.write_enable  = (state_d == ST_CONVERT);
    ctrl_d.counter_reset = (state_d == ST_CONVERT) && (state_q != ST_CONVERT);
    ctrl_d.counter_clock = (state_d == ST_CONVERT) && (state_q == ST_CONVERT);
    ctrl_d.read_reset    = (state_d == ST_READ) && (state_q != ST_READ);
    ctrl_d.read_clk_in   = (state_d == ST_READ) && (state_q == ST_READ) && !ctrl_q.read_clk_in;
  end

  assign POWER_ENABLE  = ctrl_q.power_enable;
  assign WRITE_ENABLE  = ctrl_q.write_enable;
  assign COUNTER_RESET = ctrl_q.counter_reset;
  assign COUNTER_CLOCK = ctrl_q.counter_clock;
  assign RESET         = ctrl_q.reset;
  assign ERASE         = ctrl_q.erase;
  assign EXPOSE        = ctrl_q.expose;
  assign READ_RESET    = ctrl_q.read_reset;
  assign READ_CLK_IN   = ctrl_q.read_clk_in;
  assign BUSY          = ctrl_q.busy;
  assign FRAME_DONE    = ctrl_q.frame_done;
  assign RAMP_CODE     = ramp_q;
  assign FRAME_COUNT   = frame_count_q;

endmodule

// File: tb/tb_pixel_frame_sequencer.sv
// Randomized bench for pixel_frame_sequencer: per-cycle output traces built from the frame phase rules.
module tb_pixel_frame_sequencer;

  typedef logic [34:0] obs_t;

  // Control field order: busy, frame_done, power_en, write_en, cnt_rst, cnt_clk, reset, erase, expose, read_rst, read_clk.
  localparam logic [10:0] C_IDLE     = 11'b000_0000_0000;
  localparam logic [10:0] C_ERASE    = 11'b100_0001_1000;
  localparam logic [10:0] C_EXPOSE   = 11'b100_0000_0100;
  localparam logic [10:0] C_CONV_RST = 11'b101_1100_0000;
  localparam logic [10:0] C_CONV_RUN = 11'b101_1010_0000;
  localparam logic [10:0] C_READ_RST = 11'b100_0000_0010;
  localparam logic [10:0] C_READ_HI  = 11'b100_0000_0001;
  localparam logic [10:0] C_READ_LO  = 11'b100_0000_0000;
  localparam logic [10:0] C_DONE     = 11'b110_0000_0000;
  localparam int          ERASE_N    = 5;

  logic        clk;
  logic        rst_n;
  logic        start_v [2];
  logic        cont_v  [2];
  logic        abort_v [2];
  logic [15:0] expo_v  [2];

  wire [10:0] ctl0, ctl1;
  wire [7:0]  ramp0;
  wire [3:0]  ramp1;
  wire [15:0] fc0, fc1;
  wire obs_t  obs0 = {ctl0, ramp0, fc0};
  wire obs_t  obs1 = {ctl1, 4'b0000, ramp1, fc1};

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_fc [2];
  obs_t        exp_trace [$];

  pixel_frame_sequencer dut (
    .SYSTEM_CLK      (clk),
    .SYSTEM_RESET    (rst_n),
    .START           (start_v[0]),
    .CONTINUOUS      (cont_v[0]),
    .ABORT           (abort_v[0]),
    .EXPOSURE_CYCLES (expo_v[0]),
    .POWER_ENABLE    (ctl0[8]),
    .WRITE_ENABLE    (ctl0[7]),
    .COUNTER_RESET   (ctl0[6]),
    .COUNTER_CLOCK   (ctl0[5]),
    .RESET           (ctl0[4]),
    .ERASE           (ctl0[3]),
    .EXPOSE          (ctl0[2]),
    .READ_RESET      (ctl0[1]),
    .READ_CLK_IN     (ctl0[0]),
    .RAMP_CODE       (ramp0),
    .BUSY            (ctl0[10]),
    .FRAME_DONE      (ctl0[9]),
    .FRAME_COUNT     (fc0)
  );

  pixel_frame_sequencer #(
    .WIDTH                  (4),
    .HEIGHT                 (4),
    .OUTPUT_BUS_PIXEL_WIDTH (4),
    .BIT_DEPTH              (4)
  ) dut4 (
    .SYSTEM_CLK      (clk),
    .SYSTEM_RESET    (rst_n),
    .START           (start_v[1]),
    .CONTINUOUS      (cont_v[1]),
    .ABORT           (abort_v[1]),
    .EXPOSURE_CYCLES (expo_v[1]),
    .POWER_ENABLE    (ctl1[8]),
    .WRITE_ENABLE    (ctl1[7]),
    .COUNTER_RESET   (ctl1[6]),
    .COUNTER_CLOCK   (ctl1[5]),
    .RESET           (ctl1[4]),
    .ERASE           (ctl1[3]),
    .EXPOSE          (ctl1[2]),
    .READ_RESET      (ctl1[1]),
    .READ_CLK_IN     (ctl1[0]),
    .RAMP_CODE       (ramp1),
    .BUSY            (ctl1[10]),
    .FRAME_DONE      (ctl1[9]),
    .FRAME_COUNT     (fc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input obs_t got, input obs_t want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: observed 0x%09h required 0x%09h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic obs_t obs(input int sel);
    return (sel == 0) ? obs0 : obs1;
  endfunction

  function automatic obs_t vec(input logic [10:0] c, input int ramp, input logic [15:0] fc);
    return {c, 8'(ramp), fc};
  endfunction

  // Expected per-cycle outputs of one whole frame, from ERASE through DONE.
  task automatic build_frame(input int sel, input int expo);
    int bd;
    int nw;
    bd = (sel == 0) ? 8 : 4;
    nw = (sel == 0) ? 2 : 4;
    for (int i = 0; i < ERASE_N; i++) exp_trace.push_back(vec(C_ERASE, 0, exp_fc[sel]));
    for (int i = 0; i < ((expo == 0) ? 1 : expo); i++) exp_trace.push_back(vec(C_EXPOSE, 0, exp_fc[sel]));
    exp_trace.push_back(vec(C_CONV_RST, 0, exp_fc[sel]));
    for (int r = 0; r < (1 << bd); r++) exp_trace.push_back(vec(C_CONV_RUN, r, exp_fc[sel]));
    exp_trace.push_back(vec(C_READ_RST, 0, exp_fc[sel]));
    for (int w = 0; w < nw; w++) begin
      exp_trace.push_back(vec(C_READ_HI, 0, exp_fc[sel]));
      exp_trace.push_back(vec(C_READ_LO, 0, exp_fc[sel]));
    end
    exp_fc[sel] = exp_fc[sel] + 16'd1;
    exp_trace.push_back(vec(C_DONE, 0, exp_fc[sel]));
  endtask

  // Start n back-to-back frames; inputs that must be ignored are randomized along the way.
  task automatic run_frames(input string tag, input int sel, input int n, input int expo,
                            input bit mutate, input int abort_at);
    int          e;
    int          idx;
    bit          cont;
    bit          last;
    obs_t        ev;
    logic [15:0] fc_before;
    e            = expo;
    expo_v[sel]  = 16'(e);
    start_v[sel] = 1'b1;
    @(posedge clk); #1;
    for (int f = 0; f < n; f++) begin
      cont      = (f < n - 1);
      fc_before = exp_fc[sel];
      build_frame(sel, e);
      idx = 0;
      while (exp_trace.size() > 0) begin
        ev   = exp_trace.pop_front();
        last = (exp_trace.size() == 0);
        check(tag, obs(sel), ev);
        start_v[sel] = last ? 1'b0 : ($urandom_range(0, 7) == 0);
        cont_v[sel]  = last ? cont : 1'($urandom_range(0, 1));
        if (mutate && ($urandom_range(0, 31) == 0)) expo_v[sel] = 16'($urandom_range(0, 15));
        if ((f == n - 1) && (idx == abort_at)) begin
          abort_v[sel] = 1'b1;
          @(posedge clk); #1;
          abort_v[sel] = 1'b0;
          start_v[sel] = 1'b0;
          cont_v[sel]  = 1'b0;
          exp_trace.delete();
          exp_fc[sel] = fc_before;
          check({tag, "_abort"}, obs(sel), vec(C_IDLE, 0, exp_fc[sel]));
          return;
        end
        @(posedge clk); #1;
        idx++;
      end
      e = int'(expo_v[sel]);
    end
    start_v[sel] = 1'b0;
    cont_v[sel]  = 1'b0;
    check({tag, "_idle"}, obs(sel), vec(C_IDLE, 0, exp_fc[sel]));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int s = 0; s < 2; s++) begin
      start_v[s] = 1'b0; cont_v[s] = 1'b0; abort_v[s] = 1'b0; expo_v[s] = '0; exp_fc[s] = '0;
    end
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("reset_state", obs(0), vec(C_IDLE, 0, 16'd0));
    check("reset_state4", obs(1), vec(C_IDLE, 0, 16'd0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // START held in IDLE is the only way out; ABORT alone leaves IDLE alone.
    abort_v[0] = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check("abort_in_idle", obs(0), vec(C_IDLE, 0, exp_fc[0]));
    end
    abort_v[0] = 1'b0;

    run_frames("default_frame", 0, 1, 10, 1'b0, -1);
    run_frames("zero_exposure", 0, 1, 0, 1'b0, -1);
    run_frames("continuous3", 0, 3, 7, 1'b1, -1);
    check("count_after_cont", obs(0), vec(C_IDLE, 0, 16'd5));
    run_frames("abort_conv100", 0, 1, 4, 1'b0, ERASE_N + 4 + 100);
    run_frames("after_abort", 0, 1, 2, 1'b0, -1);

    for (int k = 0; k < 6; k++) begin
      run_frames("random", 0, $urandom_range(1, 3), $urandom_range(0, 12), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 1) == 1) ? $urandom_range(0, 290) : -1);
    end

    // Asynchronous reset in the middle of READ.
    expo_v[0]  = 16'd2;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    build_frame(0, 2);
    for (int i = 0; i <= ERASE_N + 2 + 257 + 2; i++) begin
      check("pre_reset", obs(0), exp_trace.pop_front());
      if (i != ERASE_N + 2 + 257 + 2) begin
        @(posedge clk); #1;
      end
    end
    exp_trace.delete();
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", obs(0), vec(C_IDLE, 0, 16'd0));
    exp_fc[0] = '0;
    exp_fc[1] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_after_reset", obs(0), vec(C_IDLE, 0, 16'd0));

    // Preset the frame counter to its last value and watch it wrap at DONE.
    force dut.frame_count_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut.frame_count_q;
    exp_fc[0] = 16'hFFFF;
    @(posedge clk); #1;
    check("preset_count", obs(0), vec(C_IDLE, 0, 16'hFFFF));
    run_frames("count_wrap", 0, 1, 3, 1'b0, -1);
    check("wrapped_count", obs(0), vec(C_IDLE, 0, 16'd0));

    run_frames("small_array", 1, 1, 3, 1'b0, -1);
    run_frames("small_array_cont", 1, 2, $urandom_range(0, 6), 1'b1, -1);
    run_frames("small_array_abort", 1, 1, 1, 1'b0, $urandom_range(0, 20));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
